serial_word_collector: RTL

//  Deserializer that takes one serial bit per accepted cycle and assembles
//  N-bit words, MSB first. It sits directly downstream of the serial shift

---
 rtl/serial_word_collector.sv | 95 +++++++++
 1 files changed

// File: rtl/serial_word_collector.sv
// serial_word_collector: MSB-first serial-to-parallel deserializer with a
// one-entry output register and valid/ready handshake on the word side.
// Optional feature macro: DESER_PARITY_EN. When defined, every frame carries
// one trailing even-parity bit and out_perr reports a parity error for the
// word in the output register. When undefined, frames are N bits long and
// out_perr is tied to 0.
module serial_word_collector #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_bit,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_word,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_perr
);

`ifdef DESER_PARITY_EN
    localparam int F = N + 1;
`else
    localparam int F = N;
`endif

    // The shift register only keeps the bits that precede the final bit of a
    // frame; the final bit is taken straight from in_bit on completion.
    localparam int SREG_W = F - 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(F - 1);

    // Output register occupancy: HOLD while out_word carries an unconsumed word.
    typedef enum logic {
        FREE = 1'b0,
        HOLD = 1'b1
    } out_state_t;

    out_state_t        out_state;
    logic [SREG_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic [SREG_W:0]   frame_bits;
    logic              last_bit;
    logic              accept;
    logic              complete;

    // A whole frame as it would look if the current bit were accepted now.
    assign frame_bits = {sreg, in_bit};
    assign last_bit   = (cnt == LAST);
    assign out_valid  = (out_state == HOLD);

    // Stall only when this bit would finish a word and the output is still full.
    assign in_ready = !(last_bit && out_valid && !out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign complete = accept && last_bit;

    // Collection side: shift accepted bits in and count position in the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (flush) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= frame_bits[SREG_W-1:0];
            cnt  <= last_bit ? '0 : cnt + 1'b1;
        end
    end

    // Output side: load a completed word, otherwise release it when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= FREE;
            out_word  <= '0;
`ifdef DESER_PARITY_EN
            out_perr  <= 1'b0;
`endif
        end else if (complete) begin
            out_state <= HOLD;
            out_word  <= frame_bits[SREG_W -: N];
`ifdef DESER_PARITY_EN
            out_perr  <= ^frame_bits;
`endif
        end else if (out_ready) begin
            out_state <= FREE;
        end
    end

`ifndef DESER_PARITY_EN
    assign out_perr = 1'b0;
`endif

endmodule
